writeback_buffer: RTL and testbench

- Sits on the RAM side of the two-way data cache.
- Absorbs dirty evictions emitted by the cache (write-enable, data, address) into a small FIFO and drains them to data RAM one word per cycle under RAM backpressure.
- Forwards buffered data to cache miss fills so a line re-fetched before its eviction drains is never stale.
- Coalesces repeated evictions to the same word.

---
 rtl/wb_pkg.sv | 19 +
 rtl/writeback_buffer_if.sv | 34 +++
 rtl/wb_match.sv | 31 +++
 rtl/writeback_buffer.sv | 104 ++++++++++
 tb/tb_writeback_buffer.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared types and helpers for the write-back buffer that sits between the data cache and data RAM.
package wb_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 32;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wb_entry_t;

    // Word-granular compare: byte-offset bits are ignored.
    function automatic logic word_match(input logic [ADDR_WIDTH-1:0] a,
                                        input logic [ADDR_WIDTH-1:0] b);
        return a[ADDR_WIDTH-1:2] == b[ADDR_WIDTH-1:2];
    endfunction

endpackage

// File: rtl/writeback_buffer_if.sv
// Cache-side eviction/fill signals and RAM-side port of the write-back buffer.
interface writeback_buffer_if
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                  we_from_cache;
    logic [DATA_WIDTH-1:0] wd_from_cache;
    logic [ADDR_WIDTH-1:0] w_addr_from_cache;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_to_cache;
    logic [ADDR_WIDTH-1:0] ram_r_addr;
    logic [DATA_WIDTH-1:0] ram_rd;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_w_addr;
    logic [DATA_WIDTH-1:0] ram_wd;
    logic                  ram_ready;
    logic                  stall;
    logic                  full;
    logic [CW-1:0]         count;

    modport slave (
        input  we_from_cache, wd_from_cache, w_addr_from_cache, rd_addr, ram_rd, ram_ready,
        output rd_to_cache, ram_r_addr, ram_we, ram_w_addr, ram_wd, stall, full, count
    );

    modport master (
        output we_from_cache, wd_from_cache, w_addr_from_cache, rd_addr, ram_rd, ram_ready,
        input  rd_to_cache, ram_r_addr, ram_we, ram_w_addr, ram_wd, stall, full, count
    );

endinterface

// File: rtl/wb_match.sv
// Combinational CAM over the buffer entries; a non-head hit is the newest and wins over the head.
module wb_match
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW   = $clog2(DEPTH)
) (
    input  wb_entry_t             entries_i [DEPTH],
    input  logic [PW-1:0]         head_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  retiring_i,
    output logic [DEPTH-1:0]      match_o,
    output logic                  hit_o,
    output logic [PW-1:0]         idx_o
);

    always_comb begin
        match_o = '0;
        hit_o   = 1'b0;
        idx_o   = head_i;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entries_i[i].valid && word_match(entries_i[i].addr, addr_i) &&
                !(retiring_i && head_i == PW'(i))) begin
                match_o[i] = 1'b1;
                hit_o      = 1'b1;
                if (head_i != PW'(i)) idx_o = PW'(i);
            end
        end
    end

endmodule

// File: rtl/writeback_buffer.sv
// Write-back buffer: absorbs dirty evictions, drains one word per cycle to RAM, forwards and coalesces.
module writeback_buffer
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input logic               clk,
    input logic               rst,
    writeback_buffer_if.slave bus
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    wb_entry_t         entries_q [DEPTH];
    wb_entry_t         entries_d [DEPTH];
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;

    logic              ram_we;
    logic              full;
    logic              alloc;
    logic              f_hit, c_hit;
    logic [PW-1:0]     f_idx, c_idx;
    logic [DEPTH-1:0]  f_match, c_match;
    logic              wb_unused;

    wb_match #(.DEPTH(DEPTH)) u_fwd_match (
        .entries_i (entries_q),
        .head_i    (head_q),
        .addr_i    (bus.rd_addr),
        .retiring_i(1'b0),
        .match_o   (f_match),
        .hit_o     (f_hit),
        .idx_o     (f_idx)
    );

    wb_match #(.DEPTH(DEPTH)) u_coal_match (
        .entries_i (entries_q),
        .head_i    (head_q),
        .addr_i    (bus.w_addr_from_cache),
        .retiring_i(ram_we),
        .match_o   (c_match),
        .hit_o     (c_hit),
        .idx_o     (c_idx)
    );

    assign wb_unused = ^{f_match, c_idx};

    // Strobe is suppressed under reset so pending entries are discarded, never written.
    assign ram_we = !rst && (count_q != '0) && bus.ram_ready;
    assign full   = (count_q == CW'(DEPTH));
    assign alloc  = bus.we_from_cache && !c_hit && (!full || ram_we);

    assign bus.ram_we      = ram_we;
    assign bus.ram_w_addr  = entries_q[head_q].addr;
    assign bus.ram_wd      = entries_q[head_q].data;
    assign bus.ram_r_addr  = bus.rd_addr;
    assign bus.rd_to_cache = f_hit ? entries_q[f_idx].data : bus.ram_rd;
    assign bus.stall       = bus.we_from_cache && full && !ram_we && !c_hit;
    assign bus.full        = full;
    assign bus.count       = count_q;

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (ram_we) begin
            entries_d[head_q].valid = 1'b0;
            head_d = head_q + PW'(1);
        end
        if (bus.we_from_cache) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (c_match[i]) entries_d[i].data = bus.wd_from_cache;
            end
        end
        // Allocation comes last: when full and retiring, tail aliases head and the new entry must survive.
        if (alloc) begin
            entries_d[tail_q] = '{valid: 1'b1, addr: bus.w_addr_from_cache, data: bus.wd_from_cache};
            tail_d = tail_q + PW'(1);
        end
        case ({alloc, ram_we})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) entries_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_writeback_buffer.sv
// Bench for writeback_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_writeback_buffer;
    import wb_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    writeback_buffer_if #(.DEPTH(DEPTH)) bus ();

    writeback_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit same_word(input logic [31:0] a, input logic [31:0] b);
        return (a >> 2) == (b >> 2);
    endfunction

    // One clock: drive inputs after the falling edge, check just before the rising edge, advance the model.
    task automatic cycle(input logic r, input logic we, input logic [31:0] wa, input logic [31:0] wd,
                         input logic [31:0] ra, input logic [31:0] rrd, input logic rdy);
        int fwd_i;
        int co_i;
        logic [31:0] exp_rd;
        logic exp_we, exp_full, exp_stall;
        @(negedge clk);
        rst                   = r;
        bus.we_from_cache     = we;
        bus.w_addr_from_cache = wa;
        bus.wd_from_cache     = wd;
        bus.rd_addr           = ra;
        bus.ram_rd            = rrd;
        bus.ram_ready         = rdy;
        #2;
        if (r) begin
            chk("rst_ram_we", 64'(bus.ram_we), 64'(0));
            q.delete();
            return;
        end
        exp_we   = (q.size() != 0) && rdy;
        exp_full = (q.size() == DEPTH);
        fwd_i = -1;
        for (int i = 0; i < q.size(); i++) if (same_word(q[i].a, ra)) fwd_i = i;
        exp_rd = (fwd_i >= 0) ? q[fwd_i].d : rrd;
        co_i = -1;
        for (int i = (exp_we ? 1 : 0); i < q.size(); i++) if (same_word(q[i].a, wa)) co_i = i;
        exp_stall = we && exp_full && !exp_we && (co_i < 0);

        chk("ram_we",      64'(bus.ram_we),      64'(exp_we));
        chk("count",       64'(bus.count),       64'(q.size()));
        chk("full",        64'(bus.full),        64'(exp_full));
        chk("stall",       64'(bus.stall),       64'(exp_stall));
        chk("rd_to_cache", 64'(bus.rd_to_cache), 64'(exp_rd));
        chk("ram_r_addr",  64'(bus.ram_r_addr),  64'(ra));
        if (exp_we) begin
            chk("ram_w_addr", 64'(bus.ram_w_addr), 64'(q[0].a));
            chk("ram_wd",     64'(bus.ram_wd),     64'(q[0].d));
        end

        if (we && co_i >= 0) q[co_i].d = wd;
        if (exp_we) void'(q.pop_front());
        if (we && co_i < 0 && (!exp_full || exp_we)) q.push_back('{a: wa, d: wd});
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF, rdy);
    endtask

    task automatic evict(input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] ra, input logic rdy);
        cycle(1'b0, 1'b1, wa, wd, ra, 32'h0, rdy);
    endtask

    initial begin
        // Reset, then idle with ram_rd visible through the buffer.
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 1'b1);
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 1'b1);
        idle(1'b1, 2);

        // Two buffered evictions, forwarding of the second while RAM reads zero.
        evict(32'h100, 32'h11, 32'h0, 1'b0);
        evict(32'h200, 32'h22, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 32'h200, 32'h0, 1'b0);
        chk("fwd_0x200", 64'(bus.rd_to_cache), 64'h22);
        idle(1'b1, 3);

        // Coalesce of a byte-offset alias of the same word.
        evict(32'h100, 32'h11, 32'h0, 1'b0);
        evict(32'h102, 32'h33, 32'h100, 1'b0);
        idle(1'b0, 1);
        chk("coalesce_count", 64'(bus.count), 64'd1);
        idle(1'b1, 2);

        // Full buffer stalls, then a drain in the same cycle admits the retried eviction.
        evict(32'h100, 32'h1, 32'h0, 1'b0);
        evict(32'h200, 32'h2, 32'h0, 1'b0);
        evict(32'h300, 32'h3, 32'h0, 1'b0);
        evict(32'h400, 32'h4, 32'h0, 1'b0);
        evict(32'h500, 32'h5, 32'h500, 1'b0);
        chk("stall_full", 64'(bus.stall), 64'd1);
        evict(32'h500, 32'h5, 32'h500, 1'b1);
        chk("stall_drain", 64'(bus.stall), 64'd0);
        idle(1'b0, 1);
        chk("count_after_swap", 64'(bus.count), 64'd4);
        idle(1'b1, 5);

        // Eviction to the retiring head becomes a fresh entry.
        evict(32'h100, 32'h11, 32'h100, 1'b0);
        evict(32'h100, 32'h44, 32'h100, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 32'h100, 32'h0, 1'b0);
        chk("fwd_new_head", 64'(bus.rd_to_cache), 64'h44);
        idle(1'b1, 2);

        // Reset discards pending entries.
        evict(32'h100, 32'hA, 32'h0, 1'b0);
        evict(32'h200, 32'hB, 32'h0, 1'b0);
        evict(32'h300, 32'hC, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
        idle(1'b1, 3);

        for (int n = 0; n < 3000; n++) begin
            logic r, we, rdy;
            logic [31:0] wa, ra;
            r   = ($urandom_range(0, 199) == 0);
            we  = ($urandom_range(0, 9) < 6);
            rdy = ($urandom_range(0, 1) == 1);
            wa  = (32'($urandom_range(1, 6)) << 8) | 32'($urandom_range(0, 3));
            ra  = (32'($urandom_range(1, 7)) << 8) | 32'($urandom_range(0, 3));
            cycle(r, we, wa, $urandom, ra, $urandom, rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
